bus_reg_file: RTL and testbench
===============================

# bus_reg_file

Parametrised bank of DEPTH bus-attached registers of WIDTH bits, sharing one tri-state CPU bus. It generalises the single bus register to multiple selectable entries. Each entry can also count up or down in place, so it can act as a general register, a loop counter or a stack/index pointer. It sits on the shared bus next to the ALU and memory address logic, driven by the control unit's load/drive/count strobes.

## Interface

- WIDTH, 8, bit width of each register and of the bus
- DEPTH, 4, number of registers; power of two, >= 2; SELW = $clog2(DEPTH)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- sel  in  SELW  selects the register addressed by every operation and by value/zero
- read_from_bus  in  1  load selected register from bus
- write_to_bus  in  1  drive selected register onto bus
- inc  in  1  increment selected register
- dec  in  1  decrement selected register
- bus  inout  WIDTH  shared tri-state CPU bus
- value  out  WIDTH  current contents of selected register (combinational on sel)
- zero  out  1  high when value == 0
- carry  out  1  registered carry/borrow flag from last inc/dec (see Configuration)

## Operation

- Storage: DEPTH x WIDTH flops, regs[0..DEPTH-1]; only regs[sel] changes in a cycle.
- Per-edge priority on regs[sel]: rst > read_from_bus > inc/dec > hold.
  - read_from_bus=1: regs[sel] <= bus; inc/dec ignored; carry <= 0.
  - inc=1, dec=0: regs[sel] <= regs[sel]+1 mod 2^WIDTH; carry <= 1 only when the old value was all ones (wrap), else 0.
  - dec=1, inc=0: regs[sel] <= regs[sel]-1 mod 2^WIDTH; carry <= 1 only when the old value was 0 (borrow), else 0.
  - inc=1 and dec=1: no change to regs or carry.
  - none asserted: hold all regs and carry.
- Bus drive: bus = regs[sel] when write_to_bus && !read_from_bus, else high-Z. A register never drives and loads in the same cycle.
- Drive with count: bus carries the pre-update value during that cycle; the new value is visible the next cycle.
- value/zero track sel combinationally; changing sel alone alters no state.

## Timing

- Reset: all regs = 0, carry = 0, bus high-Z. With sel = 0, value = 0 and zero = 1. Assertion takes effect immediately, mid-operation included; state is frozen until rst deasserts. Operations resume on the first rising edge after deassertion.
- Load and count latency: 1 cycle. The result appears on value and zero after the edge that samples the strobe.
- Bus drive: combinational from write_to_bus, read_from_bus and sel. No cycle latency and no registered enable.
- carry: updated on the same edge as the count. It holds until the next load or count on any register, because the flag is global.

## Configuration

- REGFILE_CARRY_EN defined: carry flag register present and behaves as above.
- Not defined: no flag register; carry output tied to 0. Count wrap-around of regs is unchanged.

## Test plan

- Reset mid-count: with regs[2] = 8'h05 and inc high, assert rst between edges -> all regs 0, carry 0, bus Z immediately. After release with sel = 0: value = 0, zero = 1.
- Load/drive: sel=1, bus=8'hA5, read_from_bus 1 cycle -> value=8'hA5. Then write_to_bus=1 -> bus=8'hA5; other regs still 0.
- Wrap: regs[3]=8'hFF, inc 1 cycle -> regs[3]=8'h00, zero=1, carry=1. Then dec -> 8'hFF, carry=1. Then dec -> 8'hFE, carry=0.
- Conflicts: read_from_bus + write_to_bus -> bus Z, load occurs. read_from_bus + inc with bus=8'h10 -> reg=8'h10, carry=0. inc + dec -> no change.
- Drive while counting: regs[0]=8'h07, write_to_bus + inc -> bus=8'h07 that cycle, value=8'h08 after the edge.
- Macro off: rerun the wrap scenario without REGFILE_CARRY_EN -> identical reg values, carry constantly 0.

Source files
------------

// File: rtl/bus_reg_file_if.sv
// bus_reg_file_if: select, strobes and status of the register bank.
// The tri-state data bus itself stays a plain inout on the bank.
interface bus_reg_file_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int SELW = $clog2(DEPTH);

  logic [SELW-1:0]  sel;
  logic             read_from_bus;
  logic             write_to_bus;
  logic             inc;
  logic             dec;
  logic [WIDTH-1:0] value;
  logic             zero;
  logic             carry;

  modport master (
    output sel,
    output read_from_bus,
    output write_to_bus,
    output inc,
    output dec,
    input  value,
    input  zero,
    input  carry
  );

  modport slave (
    input  sel,
    input  read_from_bus,
    input  write_to_bus,
    input  inc,
    input  dec,
    output value,
    output zero,
    output carry
  );
endinterface

// File: rtl/bus_reg_file.sv
// bus_reg_file: DEPTH x WIDTH bus registers, each loadable/countable.
// Optional carry/borrow flag enabled by macro REGFILE_CARRY_EN.
module bus_reg_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] bus,
  bus_reg_file_if.slave    bif
);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] next_val;
  logic             upd;
  logic             drive;

  assign cur   = regs[bif.sel];
  assign drive = bif.write_to_bus && !bif.read_from_bus;

  // Next value of the selected entry: load beats count, inc+dec cancels.
  always_comb begin
    next_val = cur;
    upd      = 1'b0;
    if (bif.read_from_bus) begin
      next_val = bus;
      upd      = 1'b1;
    end else if (bif.inc && !bif.dec) begin
      next_val = cur + 1'b1;
      upd      = 1'b1;
    end else if (bif.dec && !bif.inc) begin
      next_val = cur - 1'b1;
      upd      = 1'b1;
    end
  end

  // Storage: async clear, only the selected entry updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (upd) begin
      regs[bif.sel] <= next_val;
    end
  end

`ifdef REGFILE_CARRY_EN
  logic flag_upd;
  logic flag_nxt;
  logic carry_q;

  // Carry/borrow from the old value; a load clears it.
  always_comb begin
    flag_upd = 1'b0;
    flag_nxt = 1'b0;
    if (bif.read_from_bus) begin
      flag_upd = 1'b1;
      flag_nxt = 1'b0;
    end else if (bif.inc && !bif.dec) begin
      flag_upd = 1'b1;
      flag_nxt = &cur;
    end else if (bif.dec && !bif.inc) begin
      flag_upd = 1'b1;
      flag_nxt = ~|cur;
    end
  end

  // One global flag, held until the next load or count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else if (flag_upd) begin
      carry_q <= flag_nxt;
    end
  end

  assign bif.carry = carry_q;
`else
  assign bif.carry = 1'b0;
`endif

  assign bif.value = cur;
  assign bif.zero  = (cur == '0);
  assign bus       = drive ? cur : 'z;
endmodule

// File: tb/tb_bus_reg_file.sv
// tb_bus_reg_file: directed checks of the register bank.
// Expected carry follows REGFILE_CARRY_EN.
module tb_bus_reg_file;
`ifdef REGFILE_CARRY_EN
  localparam logic CE = 1'b1;
`else
  localparam logic CE = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] drv;
  logic       en;
  wire  [7:0] bus;
  int         errors;
  int         checks;

  bus_reg_file_if #(.WIDTH(8), .DEPTH(4)) bif ();

  bus_reg_file #(.WIDTH(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .bif (bif)
  );

  assign bus = en ? drv : 'z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] s, input logic [7:0] v);
    bif.sel = s;
    drv = v;
    en = 1'b1;
    bif.read_from_bus = 1'b1;
    step();
    bif.read_from_bus = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    en = 1'b0;
    drv = 8'h00;
    bif.sel = 2'd0;
    bif.read_from_bus = 1'b0;
    bif.write_to_bus = 1'b0;
    bif.inc = 1'b0;
    bif.dec = 1'b0;
    step();
    step();
    chk("rst_value", bif.value, 0);
    chk("rst_zero", bif.zero, 1);
    chk("rst_carry", bif.carry, 0);
    rst = 1'b0;
    #2;

    // reset mid-count
    load(2'd2, 8'h05);
    chk("ld2_value", bif.value, 8'h05);
    bif.inc = 1'b1;
    step();
    chk("inc2_value", bif.value, 8'h06);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_value", bif.value, 0);
    chk("midrst_carry", bif.carry, 0);
    step();
    chk("frozen_value", bif.value, 0);
    rst = 1'b0;
    bif.inc = 1'b0;
    bif.sel = 2'd0;
    #1;
    chk("post_rst_value", bif.value, 0);
    chk("post_rst_zero", bif.zero, 1);

    // load / drive
    load(2'd1, 8'hA5);
    chk("ld1_value", bif.value, 8'hA5);
    chk("ld1_zero", bif.zero, 0);
    bif.write_to_bus = 1'b1;
    #1;
    chk("drive_bus", bus, 8'hA5);
    bif.write_to_bus = 1'b0;
    bif.sel = 2'd0;
    #1;
    chk("r0_still0", bif.value, 0);
    bif.sel = 2'd2;
    #1;
    chk("r2_still0", bif.value, 0);

    // wrap
    load(2'd3, 8'hFF);
    bif.inc = 1'b1;
    step();
    bif.inc = 1'b0;
    chk("wrap_inc_value", bif.value, 8'h00);
    chk("wrap_inc_zero", bif.zero, 1);
    chk("wrap_inc_carry", bif.carry, CE);
    bif.dec = 1'b1;
    step();
    chk("wrap_dec_value", bif.value, 8'hFF);
    chk("wrap_dec_carry", bif.carry, CE);
    step();
    bif.dec = 1'b0;
    chk("dec_fe_value", bif.value, 8'hFE);
    chk("dec_fe_carry", bif.carry, 0);

    // borrow on reg0, then inc+dec holds, sel change holds flag
    bif.sel = 2'd0;
    bif.dec = 1'b1;
    step();
    chk("r0_borrow_value", bif.value, 8'hFF);
    chk("r0_borrow_carry", bif.carry, CE);
    bif.inc = 1'b1;
    step();
    bif.inc = 1'b0;
    bif.dec = 1'b0;
    chk("incdec_value", bif.value, 8'hFF);
    chk("incdec_carry", bif.carry, CE);
    bif.sel = 2'd3;
    #1;
    chk("selchg_value", bif.value, 8'hFE);
    chk("selchg_carry", bif.carry, CE);

    // read + write: no drive, load happens
    bif.sel = 2'd1;
    drv = 8'h3C;
    en = 1'b1;
    bif.read_from_bus = 1'b1;
    bif.write_to_bus = 1'b1;
    #1;
    chk("rw_bus_z", bus, 8'h3C);
    step();
    bif.read_from_bus = 1'b0;
    bif.write_to_bus = 1'b0;
    en = 1'b0;
    chk("rw_value", bif.value, 8'h3C);

    // read + inc: load wins, carry cleared
    bif.sel = 2'd0;
    bif.inc = 1'b1;
    load(2'd0, 8'h10);
    bif.inc = 1'b0;
    chk("rdinc_value", bif.value, 8'h10);
    chk("rdinc_carry", bif.carry, 0);

    // drive while counting
    load(2'd0, 8'h07);
    bif.write_to_bus = 1'b1;
    bif.inc = 1'b1;
    #1;
    chk("drvcnt_bus", bus, 8'h07);
    step();
    bif.write_to_bus = 1'b0;
    bif.inc = 1'b0;
    chk("drvcnt_value", bif.value, 8'h08);
    chk("drvcnt_zero", bif.zero, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
